// File: rtl/burst_ram_responder.sv
// ============================================================================
// Module   : burst_ram_responder
// Brief    : On-chip BRAM responder for the burst RAM interface. Fixed-length
//            read/write bursts with a fixed read latency. Define
//            BURST_RAM_RESPONDER_CHECK_EN to build the sticky protocol checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_ram_responder #(
  parameter int DEPTH_BITWIDTH = 10,
  parameter int BURST_BEATS    = 4,
  parameter int READ_LATENCY   = 4,
  parameter int INIT_CYCLES    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd,
  input  logic                      cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] addr,
  input  logic [63:0]               wr_data,
  input  logic [7:0]                data_mask,
  output logic [63:0]               rd_data,
  output logic                      rd_data_valid,
  output logic                      init_calib,
  output logic                      busy,
  output logic                      protocol_error
);

  localparam int c_DEPTH     = 1 << DEPTH_BITWIDTH;
  localparam int c_BEAT_BITS = $clog2(BURST_BEATS);
  localparam int c_HI_BITS   = DEPTH_BITWIDTH - c_BEAT_BITS;
  localparam int c_INIT_W    = $clog2(INIT_CYCLES + 1);

  localparam logic [2:0] c_ST_INIT      = 3'd0;
  localparam logic [2:0] c_ST_IDLE      = 3'd1;
  localparam logic [2:0] c_ST_WRITE     = 3'd2;
  localparam logic [2:0] c_ST_READ_WAIT = 3'd3;
  localparam logic [2:0] c_ST_READ      = 3'd4;

  localparam logic [c_INIT_W-1:0]  c_INIT_LAST = c_INIT_W'(INIT_CYCLES - 1);
  localparam logic [c_INIT_W-1:0]  c_INIT_ONE  = c_INIT_W'(1);
  localparam logic [3:0]           c_LAT_ISSUE = 4'(READ_LATENCY - 2);
  localparam logic [c_BEAT_BITS:0] c_WR_LAST   = (c_BEAT_BITS + 1)'(BURST_BEATS - 1);
  localparam logic [c_BEAT_BITS:0] c_RD_DONE   = (c_BEAT_BITS + 1)'(BURST_BEATS);
  localparam logic [c_BEAT_BITS:0] c_BEAT_ONE  = (c_BEAT_BITS + 1)'(1);

  logic [2:0]                r_state;
  logic [c_INIT_W-1:0]       r_init_cnt;
  logic [3:0]                r_lat_cnt;
  logic [c_BEAT_BITS:0]      r_beat;
  logic [c_HI_BITS-1:0]      r_base_hi;
  logic                      r_init_calib;
  logic                      r_rd_valid;
  logic [63:0]               r_rd_data;
  logic [63:0]               r_mem [0:c_DEPTH-1];

  logic                      w_accept;
  logic                      w_we;
  logic [DEPTH_BITWIDTH-1:0] w_waddr;
  logic [DEPTH_BITWIDTH-1:0] w_raddr;

  assign w_accept = (r_state == c_ST_IDLE) && cmd_en;
  // Beat 0 of a write lands in the accept cycle itself, straight from the ports.
  assign w_we     = (w_accept && cmd) || (r_state == c_ST_WRITE);
  assign w_waddr  = (r_state == c_ST_WRITE) ? {r_base_hi, r_beat[c_BEAT_BITS-1:0]}
                                            : {addr[DEPTH_BITWIDTH-1:c_BEAT_BITS], {c_BEAT_BITS{1'b0}}};
  assign w_raddr  = {r_base_hi, r_beat[c_BEAT_BITS-1:0]};

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 8; i++) begin
        if (!data_mask[i]) r_mem[w_waddr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_ST_INIT;
      r_init_cnt   <= '0;
      r_lat_cnt    <= '0;
      r_beat       <= '0;
      r_base_hi    <= '0;
      r_init_calib <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      case (r_state)
        c_ST_INIT: begin
          if (r_init_cnt == c_INIT_LAST) begin
            r_init_calib <= 1'b1;
            r_state      <= c_ST_IDLE;
          end else begin
            r_init_cnt <= r_init_cnt + c_INIT_ONE;
          end
        end
        c_ST_IDLE: begin
          if (cmd_en) begin
            r_base_hi <= addr[DEPTH_BITWIDTH-1:c_BEAT_BITS];
            r_lat_cnt <= '0;
            if (cmd) begin
              r_beat  <= c_BEAT_ONE;
              r_state <= c_ST_WRITE;
            end else begin
              r_beat  <= '0;
              r_state <= c_ST_READ_WAIT;
            end
          end
        end
        c_ST_WRITE: begin
          if (r_beat == c_WR_LAST) r_state <= c_ST_IDLE;
          else                     r_beat  <= r_beat + c_BEAT_ONE;
        end
        c_ST_READ_WAIT: begin
          // Issue beat 0 one cycle early so the registered read meets the latency.
          if (r_lat_cnt == c_LAT_ISSUE) begin
            r_rd_data  <= r_mem[w_raddr];
            r_rd_valid <= 1'b1;
            r_beat     <= r_beat + c_BEAT_ONE;
            r_state    <= c_ST_READ;
          end else begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
          end
        end
        c_ST_READ: begin
          if (r_beat == c_RD_DONE) begin
            r_rd_valid <= 1'b0;
            r_state    <= c_ST_IDLE;
          end else begin
            r_rd_data <= r_mem[w_raddr];
            r_beat    <= r_beat + c_BEAT_ONE;
          end
        end
        default: r_state <= c_ST_INIT;
      endcase
    end
  end

  assign rd_data       = r_rd_data;
  assign rd_data_valid = r_rd_valid;
  assign init_calib    = r_init_calib;
  assign busy          = (r_state != c_ST_IDLE);

`ifdef BURST_RAM_RESPONDER_CHECK_EN
  logic r_perr;
  logic w_violation;

  assign w_violation = cmd_en && ((r_state != c_ST_IDLE) || (addr[c_BEAT_BITS-1:0] != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_perr <= 1'b0;
    else     r_perr <= r_perr | w_violation;
  end

  assign protocol_error = r_perr;
`else
  logic w_unused_addr_lo;
  assign w_unused_addr_lo = ^addr[c_BEAT_BITS-1:0];
  assign protocol_error   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_burst_ram_responder.sv
// ============================================================================
// Module   : tb_burst_ram_responder
// Brief    : Self-checking bench for burst_ram_responder against a word/byte
//            memory model; honours BURST_RAM_RESPONDER_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_burst_ram_responder;

  localparam int LAT   = 4;
  localparam int BEATS = 4;
`ifdef BURST_RAM_RESPONDER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd = 1'b0;
  logic        cmd_en = 1'b0;
  logic [9:0]  addr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  data_mask = '0;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        init_calib;
  logic        busy;
  logic        protocol_error;

  burst_ram_responder dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .init_calib(init_calib), .busy(busy),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_data  [1024];
  logic [7:0]  m_known [1024];
  logic [63:0] wd [4];
  logic [7:0]  wm [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] known_mask(input int w);
    logic [63:0] m = '0;
    for (int j = 0; j < 8; j++) if (m_known[w][j]) m[j*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Releases rst at a negedge; init_calib must rise exactly after the 16th clock edge.
  task automatic init_phase(input int inject_i);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cmd    = 1'b0;
      addr   = 10'h010;
      cmd_en = (i == inject_i);
      @(negedge clk);
      check("init_calib", init_calib, 64'(i == 16));
      check("init_busy", busy, 64'(i < 16));
      check("init_valid", rd_data_valid, 0);
    end
    cmd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd_en = 1'b0;
    #1;
    check("rst_rd_data", rd_data, 0);
    check("rst_valid", rd_data_valid, 0);
    check("rst_init_calib", init_calib, 0);
    check("rst_busy", busy, 1);
    check("rst_perr", protocol_error, 0);
    init_phase(0);
  endtask

  task automatic write_burst(input logic [9:0] a);
    int base = int'(a) & ~(BEATS - 1);
    cmd = 1'b1; cmd_en = 1'b1; addr = a; wr_data = wd[0]; data_mask = wm[0];
    for (int k = 1; k < BEATS; k++) begin
      @(negedge clk);
      cmd_en = 1'b0; wr_data = wd[k]; data_mask = wm[k];
      check("wr_busy", busy, 1);
      check("wr_valid", rd_data_valid, 0);
    end
    @(negedge clk);
    check("wr_busy_end", busy, 0);
    for (int k = 0; k < BEATS; k++)
      for (int j = 0; j < 8; j++)
        if (!wm[k][j]) begin
          m_data[base + k][j*8 +: 8] = wd[k][j*8 +: 8];
          m_known[base + k][j] = 1'b1;
        end
  endtask

  task automatic read_burst(input logic [9:0] a, input int inject_k);
    int base = int'(a) & ~(BEATS - 1);
    int nvalid = 0;
    logic [63:0] km;
    cmd = 1'b0; cmd_en = 1'b1; addr = a;
    for (int k = 1; k <= LAT + BEATS; k++) begin
      @(negedge clk);
      cmd_en  = (k == inject_k);
      cmd     = (k == inject_k);
      wr_data = {$urandom, $urandom};
      data_mask = 8'h00;
      nvalid += int'(rd_data_valid);
      check("rd_busy", busy, 64'(k < LAT + BEATS));
      check("rd_valid", rd_data_valid, 64'(k >= LAT && k < LAT + BEATS));
      if (k >= LAT && k < LAT + BEATS) begin
        km = known_mask(base + k - LAT);
        check("rd_beat", rd_data & km, m_data[base + k - LAT] & km);
      end else if (k == LAT + BEATS) begin
        km = known_mask(base + BEATS - 1);
        check("rd_hold", rd_data & km, m_data[base + BEATS - 1] & km);
      end
    end
    cmd_en = 1'b0; cmd = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      nvalid += int'(rd_data_valid);
    end
    check("rd_valid_count", 64'(nvalid), 64'(BEATS));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      m_data[i]  = '0;
      m_known[i] = '0;
    end

    do_reset();

    wd[0] = {8{8'h11}}; wd[1] = {8{8'h22}}; wd[2] = {8{8'h33}}; wd[3] = {8{8'h44}};
    wm = '{default: 8'h00};
    write_burst(10'h010);
    read_burst(10'h010, 0);
    check("perr_clean", protocol_error, 0);

    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; wd[1] = 64'h0123_4567_89AB_CDEF;
    wd[2] = 64'h0; wd[3] = 64'h5A5A_5A5A_A5A5_A5A5;
    write_burst(10'h020);
    wd[0] = 64'h0; wm[0] = 8'h0F; wm[1] = 8'hFF; wm[2] = 8'hFF; wm[3] = 8'hFF;
    write_burst(10'h020);
    read_burst(10'h020, 0);

    // Stray write command during READ_WAIT must be dropped.
    read_burst(10'h010, 1);
    check("perr_busy_cmd", protocol_error, 64'(CHK));
    read_burst(10'h010, 0);
    check("perr_sticky", protocol_error, 64'(CHK));

    cmd = 1'b0; cmd_en = 1'b1; addr = 10'h010;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      cmd_en = 1'b0;
    end
    check("pre_rst_valid", rd_data_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_valid", rd_data_valid, 0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_busy", busy, 1);
    check("midrst_perr", protocol_error, 0);
    init_phase(3);
    check("perr_init_cmd", protocol_error, 64'(CHK));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_burst_valid", rd_data_valid, 0);
    end
    read_burst(10'h010, 0);

    do_reset();
    read_burst(10'h013, 0);
    check("perr_unaligned", protocol_error, 64'(CHK));

    for (int n = 0; n < 40; n++) begin
      logic [9:0] a;
      a = 10'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < BEATS; k++) begin
          wd[k] = {$urandom, $urandom};
          wm[k] = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(0, 255));
        end
        write_burst(a);
      end else begin
        read_burst(a, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
